// File: rtl/imm22_narrow_pkg.sv
// Shared widths, field limits and the buffered entry type for the 22-bit immediate narrower.
package imm22_narrow_pkg;

   localparam int WORD_W = 32;
   localparam int IMM_W  = 22;

   localparam logic [IMM_W-1:0] IMM_MAX = 22'h1FFFFF;
   localparam logic [IMM_W-1:0] IMM_MIN = 22'h200000;

   typedef struct packed {
      logic             ovf;
      logic [IMM_W-1:0] data;
   } imm_entry_t;

   localparam imm_entry_t ENTRY_ZERO = '{ovf: 1'b0, data: 22'd0};

endpackage

// File: rtl/imm22_fit.sv
// Combinational 22-bit fit check with saturate (IMM22_SAT_EN defined) or truncate selection.
module imm22_fit
   import imm22_narrow_pkg::*;
(
   input  logic [WORD_W-1:0] value,
   output imm_entry_t        entry
);

   logic fits_s;

   assign fits_s = (value[WORD_W-1:IMM_W] == {(WORD_W-IMM_W){value[IMM_W-1]}});

   always_comb begin
      entry.ovf = ~fits_s;
`ifdef IMM22_SAT_EN
      if (fits_s) begin
         entry.data = value[IMM_W-1:0];
      end else if (value[WORD_W-1]) begin
         entry.data = IMM_MIN;
      end else begin
         entry.data = IMM_MAX;
      end
`else
      entry.data = value[IMM_W-1:0];
`endif
   end

endmodule

// File: rtl/imm22_narrow.sv
// 32-to-22-bit signed narrower with 2-entry output FIFO and saturating overflow counter.
// Optional build macro: IMM22_SAT_EN (saturate instead of truncate non-fitting values).
module imm22_narrow
   import imm22_narrow_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IMM_W-1:0]  out_data,
   output logic              out_ovf,
   input  logic              stat_clr,
   output logic [CNT_W-1:0]  ovf_cnt
);

   imm_entry_t       fit_s;
   imm_entry_t       head_s;
   imm_entry_t       mem_r [2];
   logic             wr_ptr_r;
   logic             rd_ptr_r;
   logic [1:0]       count_r;
   logic [CNT_W-1:0] ovf_cnt_r;
   logic             push_s;
   logic             pop_s;

   imm22_fit u_fit (
      .value (in_data),
      .entry (fit_s)
   );

   // Handshake flags come only from the registered count, never from out_ready.
   assign in_ready  = (count_r != 2'd2);
   assign out_valid = (count_r != 2'd0);
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;
   assign head_s    = mem_r[rd_ptr_r];
   assign out_data  = head_s.data;
   assign out_ovf   = head_s.ovf;
   assign ovf_cnt   = ovf_cnt_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_r[0] <= ENTRY_ZERO;
         mem_r[1] <= ENTRY_ZERO;
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= fit_s;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Clear beats a coincident increment; the counter sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_cnt_r <= {CNT_W{1'b0}};
      end else if (stat_clr) begin
         ovf_cnt_r <= {CNT_W{1'b0}};
      end else if (push_s && fit_s.ovf && (ovf_cnt_r != {CNT_W{1'b1}})) begin
         ovf_cnt_r <= ovf_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         ovf_cnt_r <= ovf_cnt_r;
      end
   end

endmodule

// File: tb/tb_imm22_narrow.sv
// Directed self-checking bench for imm22_narrow; uses a 4-bit counter so saturation is reachable.
module tb_imm22_narrow;

   localparam int CNT_W = 4;

`ifdef IMM22_SAT_EN
   localparam logic [21:0] EXP_POS_OVF = 22'h1FFFFF;
   localparam logic [21:0] EXP_NEG_OVF = 22'h200000;
   localparam logic [21:0] EXP_BIG_OVF = 22'h1FFFFF;
`else
   localparam logic [21:0] EXP_POS_OVF = 22'h200000;
   localparam logic [21:0] EXP_NEG_OVF = 22'h1FFFFF;
   localparam logic [21:0] EXP_BIG_OVF = 22'h000000;
`endif

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             out_valid;
   logic             out_ready;
   logic [21:0]      out_data;
   logic             out_ovf;
   logic             stat_clr;
   logic [CNT_W-1:0] ovf_cnt;

   int tests_run;
   int tests_failed;

   imm22_narrow #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .stat_clr  (stat_clr),
      .ovf_cnt   (ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk          = 1'b0;
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_data      = 32'd0;
      out_ready    = 1'b0;
      stat_clr     = 1'b0;
      tests_run    = 0;
      tests_failed = 0;

      step();
      step();
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data",  {10'd0, out_data},  32'd0);
      check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
      check("rst_ovf_cnt",   {28'd0, ovf_cnt},   32'd0);
      rst = 1'b0;
      step();

      // Boundary fitting values, one per cycle with out_ready high
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h001FFFFF;
      step();
      check("max_valid", {31'd0, out_valid}, 32'd1);
      check("max_data",  {10'd0, out_data},  32'h1FFFFF);
      check("max_ovf",   {31'd0, out_ovf},   32'd0);
      in_data = 32'hFFE00000;
      step();
      check("min_valid", {31'd0, out_valid}, 32'd1);
      check("min_data",  {10'd0, out_data},  32'h200000);
      check("min_ovf",   {31'd0, out_ovf},   32'd0);
      check("fit_cnt",   {28'd0, ovf_cnt},   32'd0);
      in_valid = 1'b0;
      step();
      check("drain_valid", {31'd0, out_valid}, 32'd0);

      // Just beyond each end of the range
      in_valid = 1'b1;
      in_data  = 32'h00200000;
      step();
      in_valid = 1'b0;
      check("pos_ovf_data", {10'd0, out_data}, {10'd0, EXP_POS_OVF});
      check("pos_ovf_flag", {31'd0, out_ovf},  32'd1);
      check("pos_ovf_cnt",  {28'd0, ovf_cnt},  32'd1);
      step();
      in_valid = 1'b1;
      in_data  = 32'hFFDFFFFF;
      step();
      in_valid = 1'b0;
      check("neg_ovf_data", {10'd0, out_data}, {10'd0, EXP_NEG_OVF});
      check("neg_ovf_flag", {31'd0, out_ovf},  32'd1);
      check("neg_ovf_cnt",  {28'd0, ovf_cnt},  32'd2);
      step();

      // Backpressure: fill, hold the third, then drain in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h00000011;
      step();
      check("bp1_ready", {31'd0, in_ready}, 32'd1);
      in_data = 32'h00000022;
      step();
      check("bp2_ready", {31'd0, in_ready}, 32'd0);
      in_data = 32'h00000033;
      step();
      check("bp3_ready", {31'd0, in_ready}, 32'd0);
      check("bp3_head",  {10'd0, out_data}, 32'h11);
      out_ready = 1'b1;
      step();
      check("pop1_head",  {10'd0, out_data}, 32'h22);
      check("pop1_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("pop2_head",  {10'd0, out_data},  32'h33);
      check("pop2_valid", {31'd0, out_valid}, 32'd1);
      step();
      check("pop3_valid", {31'd0, out_valid}, 32'd0);
      check("bp_cnt",     {28'd0, ovf_cnt},   32'd2);

      // Bring the counter to all-ones minus one, then saturate
      in_valid = 1'b1;
      in_data  = 32'h40000000;
      for (int i = 0; i < 12; i++) begin
         step();
      end
      check("pre_sat_cnt",  {28'd0, ovf_cnt},  32'd14);
      check("big_ovf_data", {10'd0, out_data}, {10'd0, EXP_BIG_OVF});
      step();
      check("sat_cnt_15", {28'd0, ovf_cnt}, 32'd15);
      step();
      step();
      check("sat_cnt_hold", {28'd0, ovf_cnt}, 32'd15);
      stat_clr = 1'b1;
      step();
      check("clr_wins", {28'd0, ovf_cnt}, 32'd0);
      stat_clr = 1'b0;
      in_valid = 1'b0;
      step();
      check("clr_after", {28'd0, ovf_cnt}, 32'd0);

      // Asynchronous reset with two entries buffered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h00000077;
      step();
      step();
      in_valid = 1'b0;
      check("full_ready", {31'd0, in_ready}, 32'd0);
      #1;
      rst = 1'b1;
      #1;
      check("arst_valid", {31'd0, out_valid}, 32'd0);
      check("arst_ready", {31'd0, in_ready},  32'd1);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h00000005;
      step();
      in_valid = 1'b0;
      check("post_rst_valid", {31'd0, out_valid}, 32'd1);
      check("post_rst_data",  {10'd0, out_data},  32'h000005);
      check("post_rst_ovf",   {31'd0, out_ovf},   32'd0);
      step();
      check("post_rst_empty", {31'd0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
